// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA framebuffer path.
//   ADDR_X_WIDTH / ADDR_Y_WIDTH : pixel column / row widths from the timing FSMs
//   PIXEL_WIDTH                 : framebuffer pixel width
//   FB_ADDR_WIDTH               : linear framebuffer address width (640*480 fits in 19 bits)
//   arb_state_t                 : RAM slot owner for one cycle
//   fb_wr_t                     : queued host write (address + pixel)
package vga_pkg;
  localparam int unsigned ADDR_X_WIDTH  = 10;
  localparam int unsigned ADDR_Y_WIDTH  = 9;
  localparam int unsigned PIXEL_WIDTH   = 8;
  localparam int unsigned FB_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DISP,
    ARB_HOST
  } arb_state_t;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [PIXEL_WIDTH-1:0]   data;
  } fb_wr_t;
endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous FIFO of host framebuffer writes.
//   clk, reset_n : clock, asynchronous active-low reset (clears pointers/count)
//   push         : enqueue push_data; ignored when full, even if pop is set
//   pop          : dequeue head; ignored when empty
//   head         : oldest entry (valid when !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  fb_wr_t push_data,
  input  logic   pop,
  output fb_wr_t head,
  output logic   full,
  output logic   empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fb_wr_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between display scan-out (absolute
// priority) and queued host writes drained in display-free slots.
//   clk, reset_n                  : pixel clock, asynchronous active-low reset
//   addr_x_valid/addr_x           : column from the horizontal timing FSM
//   addr_y_valid/addr_y           : row from the vertical timing FSM
//   host_wr_valid/ready/addr/data : host write port (transfer on valid && ready)
//   host_idle                     : no queued write and no RAM write in flight
//   ram_en/we/addr/wdata          : registered RAM command
//   ram_rdata                     : RAM read data, one cycle after a read command
//   pix_valid/pix_data            : displayed pixel, two cycles after the address
// Optional: define VGA_FB_ARB_STATS_EN to add stall_cnt[15:0], a saturating
// count of cycles where a queued write was blocked by the display.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_PIXELS      = 640,
  parameter int unsigned WR_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     addr_x_valid,
  input  logic [ADDR_X_WIDTH-1:0]  addr_x,
  input  logic                     addr_y_valid,
  input  logic [ADDR_Y_WIDTH-1:0]  addr_y,
  input  logic                     host_wr_valid,
  output logic                     host_wr_ready,
  input  logic [FB_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [PIXEL_WIDTH-1:0]   host_wr_data,
  output logic                     host_idle,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [FB_ADDR_WIDTH-1:0] ram_addr,
  output logic [PIXEL_WIDTH-1:0]   ram_wdata,
  input  logic [PIXEL_WIDTH-1:0]   ram_rdata,
  output logic                     pix_valid,
  output logic [PIXEL_WIDTH-1:0]   pix_data
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  arb_state_t               state;
  arb_state_t               state_nxt;
  logic                     disp_req;
  logic [FB_ADDR_WIDTH-1:0] disp_addr;
  logic                     ready_en;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  fb_wr_t                   fifo_head;
  fb_wr_t                   fifo_in;

  assign disp_req  = addr_x_valid && addr_y_valid;
  assign disp_addr = FB_ADDR_WIDTH'(addr_y) * FB_ADDR_WIDTH'(H_PIXELS)
                   + FB_ADDR_WIDTH'(addr_x);

  // ready_en holds host_wr_ready low until the first clock after reset release.
  assign host_wr_ready = ready_en && !fifo_full;
  assign host_idle     = fifo_empty && !(ram_en && ram_we);
  assign pix_data      = ram_rdata;
  assign fifo_in       = '{addr: host_wr_addr, data: host_wr_data};

  vga_wr_fifo #(
    .DEPTH(WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (host_wr_valid && host_wr_ready),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = ARB_IDLE;
    fifo_pop  = 1'b0;
    if (disp_req) begin
      state_nxt = ARB_DISP;
    end else if (!fifo_empty) begin
      state_nxt = ARB_HOST;
      fifo_pop  = 1'b1;
    end
  end

  // RAM command registers are loaded from the slot being decided; state==ARB_DISP
  // is the first stage of the pix_valid delay line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en  <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      pix_valid <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      pix_valid <= (state == ARB_DISP);
      unique case (state_nxt)
        ARB_DISP: begin
          ram_en   <= 1'b1;
          ram_we   <= 1'b0;
          ram_addr <= disp_addr;
        end
        ARB_HOST: begin
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= fifo_head.addr;
          ram_wdata <= fifo_head.data;
        end
        default: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!fifo_empty && (state_nxt == ARB_DISP) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus a randomized
// run, all compared with a queue-based reference of the slot rules and a
// behavioural framebuffer RAM.
module tb_vga_fb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        xv, yv, hv;
  logic [9:0]  xx;
  logic [8:0]  yy;
  logic [18:0] ha;
  logic [7:0]  hd;
  logic        hrdy, idle, ram_en, ram_we, pix_valid;
  logic [18:0] ram_addr;
  logic [7:0]  ram_wdata, pix_data;
  logic [7:0]  ram_rdata = 8'h00;
`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .H_PIXELS(640),
    .WR_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .addr_x_valid(xv), .addr_x(xx), .addr_y_valid(yv), .addr_y(yy),
    .host_wr_valid(hv), .host_wr_ready(hrdy), .host_wr_addr(ha), .host_wr_data(hd),
    .host_idle(idle),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .pix_valid(pix_valid), .pix_data(pix_data)
`ifdef VGA_FB_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Behavioural framebuffer: unwritten locations read back an address-derived value.
  function automatic logic [7:0] dflt(input logic [18:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  logic [7:0] ram_mem [0:524287];
  bit         ram_wr  [0:524287];
  always @(posedge clk) begin
    if (ram_en === 1'b1) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_wr[ram_addr]  <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : dflt(ram_addr);
      end
    end
  end

  // Reference model state
  typedef struct { logic [18:0] addr; logic [7:0] data; } wr_t;
  wr_t         q[$];
  logic [7:0]  ref_mem [int];
  bit          m_rdy;
  logic        m_en, m_we, m_s1, m_pv;
  logic [18:0] m_addr;
  logic [7:0]  m_wdata, m_v1, m_pix;
  int          m_stall;

  task automatic model_reset();
    q.delete();
    m_rdy = 0; m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_s1 = 0; m_pv = 0; m_stall = 0;
  endtask

  // One clock: predict the slot from current inputs, advance, settle past the edge.
  task automatic step();
    bit   ready_now;
    int   da;
    wr_t  w;
    if (!reset_n) begin
      model_reset();
      @(posedge clk); #1;
      return;
    end
    ready_now = m_rdy && (q.size() < DEPTH);
    da = (int'(yy) * 640 + int'(xx)) % (1 << 19);
    m_pv = m_s1; m_pix = m_v1; m_s1 = 0;
    if (xv && yv) begin
      if (q.size() > 0 && m_stall < 65535) m_stall++;
      m_en = 1; m_we = 0; m_addr = 19'(da); m_s1 = 1;
      m_v1 = ref_mem.exists(da) ? ref_mem[da] : dflt(19'(da));
    end else if (q.size() > 0) begin
      w = q.pop_front();
      m_en = 1; m_we = 1; m_addr = w.addr; m_wdata = w.data;
      ref_mem[int'(w.addr)] = w.data;
    end else begin
      m_en = 0; m_we = 0;
    end
    if (hv && ready_now) begin
      w.addr = ha; w.data = hd;
      q.push_back(w);
    end
    m_rdy = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0; xv = 0; yv = 0; xx = '0; yy = '0; hv = 0; ha = '0; hd = '0;
    model_reset();
    repeat (3) step();
    reset_n = 1;
    step();
    xv = 1; yv = 1; yy = 9'd7;
    for (int i = 0; i < 6; i++) begin
      xx = 10'(i); hv = (i < 3); ha = 19'(100 + i); hd = 8'(i);
      step();
    end
    hv = 0;
    #3 reset_n = 0;
    model_reset();
    #1;
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    checks++; if (ram_addr !== 19'd0) begin failures++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
    checks++; if (ram_wdata !== 8'd0) begin failures++; $display("FAIL rst_ram_wdata got=%0h exp=0", ram_wdata); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got=%b exp=0", pix_valid); end
    checks++; if (hrdy !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", hrdy); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", idle); end
    xv = 0; yv = 0;
    step();
    reset_n = 1;
    checks++; if (hrdy !== 1'b0) begin failures++; $display("FAIL rel_ready_early got=%b exp=0", hrdy); end
    step();
    checks++; if (hrdy !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", hrdy); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ram_en !== 1'b0 || idle !== 1'b1) begin
        failures++; $display("FAIL rst_discard got=en%b idle%b exp=en0 idle1", ram_en, idle);
      end
    end
  endtask

  task automatic test_scan();
    xv = 0; yv = 0; hv = 1; ha = 19'd1285; hd = 8'hA5;
    step();
    hv = 0;
    repeat (3) step();
    xv = 1; yv = 1; xx = 10'd5; yy = 9'd2;
    step();
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 19'd1285) begin
      failures++; $display("FAIL scan_cmd got=en%b we%b addr%0d exp=en1 we0 addr1285", ram_en, ram_we, ram_addr);
    end
    xv = 0; yv = 0;
    step();
    checks++; if (pix_valid !== 1'b1 || pix_data !== 8'hA5) begin
      failures++; $display("FAIL scan_pix got=v%b d%0h exp=v1 dA5", pix_valid, pix_data);
    end
    step();
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL scan_pix_end got=%b exp=0", pix_valid); end
  endtask

  task automatic test_blank_drain();
    logic [7:0] ed [4];
    xv = 0; yv = 0;
    for (int i = 0; i < 6; i++) begin
      hv = (i < 4); ha = 19'(10 + i); hd = 8'($urandom);
      if (i < 4) ed[i] = hd;
      step();
      checks++;
      if (i >= 1 && i <= 4) begin
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 19'(9 + i) || ram_wdata !== ed[i-1]) begin
          failures++; $display("FAIL drain_%0d got=we%b addr%0d d%0h exp=we1 addr%0d d%0h",
                               i, ram_we, ram_addr, ram_wdata, 9 + i, ed[i-1]);
        end
      end else if (ram_we !== 1'b0) begin
        failures++; $display("FAIL drain_gap_%0d got=we%b exp=we0", i, ram_we);
      end
    end
    hv = 0;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_idle got=%b exp=1", idle); end
  endtask

  task automatic test_contention();
    logic [18:0] ea [4];
    logic [7:0]  ed [4];
    xv = 1; yv = 1; yy = 9'd100;
    for (int i = 0; i < 16; i++) begin
      xx = 10'(i); hv = (i < 4); ha = 19'($urandom_range(0, 307199)); hd = 8'($urandom);
      if (i < 4) begin ea[i] = ha; ed[i] = hd; end
      step();
      if (i == 3) begin
        checks++; if (hrdy !== 1'b0) begin failures++; $display("FAIL cont_full_ready got=%b exp=0", hrdy); end
      end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL cont_no_we_%0d got=%b exp=0", i, ram_we); end
    end
    hv = 0; xv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (i < 4) begin
        if (ram_we !== 1'b1 || ram_addr !== ea[i] || ram_wdata !== ed[i]) begin
          failures++; $display("FAIL cont_drain_%0d got=we%b addr%0d d%0h exp=we1 addr%0d d%0h",
                               i, ram_we, ram_addr, ram_wdata, ea[i], ed[i]);
        end
      end else if (ram_en !== 1'b0 || idle !== 1'b1) begin
        failures++; $display("FAIL cont_idle got=en%b idle%b exp=en0 idle1", ram_en, idle);
      end
    end
  endtask

  task automatic test_full_simultaneous();
    logic [18:0] ea [5];
    logic [7:0]  ed [5];
    for (int i = 0; i < 5; i++) begin
      ea[i] = 19'($urandom_range(0, 307199)); ed[i] = 8'($urandom);
    end
    xv = 1; yv = 1; yy = 9'd200;
    for (int i = 0; i < 4; i++) begin
      xx = 10'(i); hv = 1; ha = ea[i]; hd = ed[i];
      step();
    end
    hv = 0; xx = 10'd4;
    step();
    xv = 0; hv = 1; ha = ea[4]; hd = ed[4];
    checks++; if (hrdy !== 1'b0) begin failures++; $display("FAIL full_ready_blank got=%b exp=0", hrdy); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        checks++; if (hrdy !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", hrdy); end
      end
      if (i == 1) hv = 0;
      checks++;
      if (i < 5) begin
        if (ram_we !== 1'b1 || ram_addr !== ea[i] || ram_wdata !== ed[i]) begin
          failures++; $display("FAIL full_order_%0d got=we%b addr%0d d%0h exp=we1 addr%0d d%0h",
                               i, ram_we, ram_addr, ram_wdata, ea[i], ed[i]);
        end
      end else if (ram_we !== 1'b0 || idle !== 1'b1) begin
        failures++; $display("FAIL full_end got=we%b idle%b exp=we0 idle1", ram_we, idle);
      end
    end
  endtask

  task automatic test_random();
    bit exp_idle, exp_rdy;
    for (int n = 0; n < 3000; n++) begin
      xv = ($urandom_range(0, 9) < 6); yv = ($urandom_range(0, 9) < 8);
      xx = 10'($urandom_range(0, 639)); yy = 9'($urandom_range(0, 479));
      hv = $urandom_range(0, 1); ha = 19'($urandom_range(0, 4095)); hd = 8'($urandom);
      step();
      exp_rdy  = m_rdy && (q.size() < DEPTH);
      exp_idle = (q.size() == 0) && !(m_en && m_we);
      checks++; if (ram_en !== m_en || ram_we !== m_we) begin
        failures++; $display("FAIL rnd_cmd_%0d got=en%b we%b exp=en%b we%b", n, ram_en, ram_we, m_en, m_we);
      end
      checks++; if (ram_addr !== m_addr || ram_wdata !== m_wdata) begin
        failures++; $display("FAIL rnd_addr_%0d got=a%0d d%0h exp=a%0d d%0h", n, ram_addr, ram_wdata, m_addr, m_wdata);
      end
      checks++; if (pix_valid !== m_pv || (m_pv && pix_data !== m_pix)) begin
        failures++; $display("FAIL rnd_pix_%0d got=v%b d%0h exp=v%b d%0h", n, pix_valid, pix_data, m_pv, m_pix);
      end
      checks++; if (hrdy !== exp_rdy || idle !== exp_idle) begin
        failures++; $display("FAIL rnd_host_%0d got=r%b i%b exp=r%b i%b", n, hrdy, idle, exp_rdy, exp_idle);
      end
`ifdef VGA_FB_ARB_STATS_EN
      checks++; if (stall_cnt !== 16'(m_stall)) begin
        failures++; $display("FAIL rnd_stall_%0d got=%0d exp=%0d", n, stall_cnt, m_stall);
      end
`endif
    end
    xv = 0; hv = 0;
    repeat (6) step();
  endtask

`ifdef VGA_FB_ARB_STATS_EN
  task automatic test_stats();
    xv = 0; yv = 0; hv = 0;
    #3 reset_n = 0;
    model_reset();
    #1;
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", stall_cnt); end
    step();
    reset_n = 1;
    step();
    xv = 1; yv = 1; yy = 9'd3; hv = 1; ha = 19'd77; hd = 8'h11;
    step();
    hv = 0;
    for (int i = 0; i < 640; i++) begin
      xx = 10'(i);
      step();
    end
    checks++; if (stall_cnt !== 16'd640) begin failures++; $display("FAIL stats_640 got=%0d exp=640", stall_cnt); end
    repeat (70000) step();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%0h exp=FFFF", stall_cnt); end
    xv = 0;
    repeat (3) step();
    checks++; if (stall_cnt !== 16'hFFFF || idle !== 1'b1) begin
      failures++; $display("FAIL stats_hold got=%0h idle%b exp=FFFF idle1", stall_cnt, idle);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_blank_drain();
    test_contention();
    test_full_simultaneous();
    test_random();
`ifdef VGA_FB_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
